registers_controller: RTL and testbench
=======================================

Name: registers_controller

Overview:
- Avalon-MM slave register block for the loopback design.
- Counts cycles on which a message strobe is asserted and exposes the count.
- Also provides a control register, a read/write scratch (debug) register and a constant version register.
- Sits on the system register bus and decodes a word-addressed window starting at ADDR_BASE.

Parameters:
- ADDR_BASE, 0, word address of register 0; offsets are computed as address minus ADDR_BASE.
- VERSION, 32'h0001_0000, constant value returned at offset 3.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- msg_enter  input  1  message strobe; counted on every clk edge where it is 1.
- reg_mm  interface (avalon_mm_if, slave side)  —  address, read, write, writedata[31:0] in; readdata[31:0], readdatavalid, waitrequest out.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - MSG_COUNT = 0, CONTROL = 32'h1 (counter enabled), DEBUG = 0.
- waitrequest is tied to 0; every access is accepted in the cycle it is presented.
- Offset decode: off = address - ADDR_BASE. Addresses outside [ADDR_BASE, ADDR_BASE+3] are unmapped.
- Register map:
  - 0 MSG_COUNT: read-only, 32-bit, increments by 1 on each edge where msg_enter=1 and CONTROL[0]=1. Wraps 0xFFFFFFFF -> 0. Writes are ignored.
  - 1 CONTROL: bit0 = count enable (R/W). bit1 = counter clear, write-1, self-clearing, always reads 0. Bits 31:2 read 0.
  - 2 DEBUG: full 32-bit R/W scratch register.
  - 3 VERSION: read-only, returns the VERSION parameter.
- Write: when write=1, writedata is stored into the addressed register on that edge. Writes to read-only or unmapped offsets are silently dropped.
- Read:
  - When read=1 at an edge, readdata is registered with the addressed value as it stood before that edge, and readdatavalid=1 for exactly one cycle.
  - Read latency is 1.
  - Unmapped reads return 0 with readdatavalid=1.
- When no read is accepted, readdatavalid=0 and readdata holds its last value.
- read and write together (illegal for a master): the write takes effect and the read returns the pre-write value.
- Clear vs. increment on the same edge: the clear wins and the counter becomes 0.
- Read of MSG_COUNT on an incrementing edge returns the old value; the new value is visible on the next read.
- Back-to-back reads on consecutive cycles give one readdatavalid pulse per read, each one cycle later.
- Reset asserted mid-operation immediately forces all registers and outputs to their reset values; any pending readdatavalid is cancelled.

Decomposition:
- Shared package registers_pkg holds:
  - offset constants REG_MSG_COUNT=0, REG_CONTROL=1, REG_DEBUG=2, REG_VERSION=3;
  - DATA_W=32;
  - CONTROL bit indices CTRL_EN=0, CTRL_CLR=1.
- One sub-module is natural: msg_counter (enable, clear, increment, 32-bit wrap counter).
- Decode and the readback mux stay in registers_controller.

Test Plan:
- Reset, then read offsets 0/1/2/3 -> readdata 0, 1, 0, VERSION, each with a one-cycle readdatavalid pulse, 1 cycle after read.
- Write 0xDEADBEEF to offset 2, idle 1 cycle, read offset 2 -> readdata=0xDEADBEEF, readdatavalid=1 for exactly one cycle, waitrequest=0 throughout.
- Read offset 0 with msg_enter=0 -> 0. Then hold msg_enter=1 for 10 edges and read on the 11th edge -> readdata=0x0000000A; a read one cycle later -> 0x0000000B.
- Write CONTROL=0 and pulse msg_enter for 5 cycles -> MSG_COUNT unchanged. Write CONTROL=0x3 -> MSG_COUNT reads 0, CONTROL reads 1.
- Write 0x12345678 to offset 0 and to offset 3 -> reads return the count and VERSION unchanged. Read ADDR_BASE+7 -> 0 with readdatavalid.
- Assert rst_n=0 mid-count (count=20) and in the cycle after a read -> readdatavalid drops immediately, and count=0, DEBUG=0 after release.

Source files
------------

// File: rtl/registers_pkg.sv
// rtl/registers_pkg.sv - shared constants for the loopback register block
package registers_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] REG_MSG_COUNT = 2'd0;
  localparam logic [1:0] REG_CONTROL   = 2'd1;
  localparam logic [1:0] REG_DEBUG     = 2'd2;
  localparam logic [1:0] REG_VERSION   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/avalon_mm_if.sv
// rtl/avalon_mm_if.sv - word-addressed memory-mapped register bus
interface avalon_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/msg_counter.sv
// rtl/msg_counter.sv - gated 32-bit message counter with synchronous clear
module msg_counter
  import registers_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  // Clear takes priority over a coincident increment; the add wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/registers_controller.sv
// rtl/registers_controller.sv - register window: message count, control, debug scratch, version
module registers_controller
  import registers_pkg::*;
#(
  parameter logic [31:0]       ADDR_BASE = 32'd0,
  parameter logic [DATA_W-1:0] VERSION   = 32'h0001_0000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_enter,
  avalon_mm_if.slave  reg_mm
);

  logic [31:0]       off;
  logic              mapped;
  logic [1:0]        idx;
  logic              wr_ctrl;
  logic              wr_dbg;
  logic              cnt_clear;
  logic              ctrl_en;
  logic [DATA_W-1:0] debug;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] rd_value;

  // Unsigned subtraction: anything below ADDR_BASE wraps to a large offset and falls out of range.
  assign off    = reg_mm.address - ADDR_BASE;
  assign mapped = (off < 32'd4);
  assign idx    = off[1:0];

  assign wr_ctrl   = reg_mm.write && mapped && (idx == REG_CONTROL);
  assign wr_dbg    = reg_mm.write && mapped && (idx == REG_DEBUG);
  assign cnt_clear = wr_ctrl && reg_mm.writedata[CTRL_CLR];

  assign reg_mm.waitrequest = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en <= 1'b1;
      debug   <= '0;
    end else begin
      if (wr_ctrl) ctrl_en <= reg_mm.writedata[CTRL_EN];
      if (wr_dbg)  debug   <= reg_mm.writedata;
    end
  end

  msg_counter u_msg_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (ctrl_en),
    .clear  (cnt_clear),
    .inc    (msg_enter),
    .count  (count)
  );

  always_comb begin
    rd_value = '0;
    if (mapped) begin
      case (idx)
        REG_MSG_COUNT: rd_value = count;
        REG_CONTROL:   rd_value = {{(DATA_W-1){1'b0}}, ctrl_en};
        REG_DEBUG:     rd_value = debug;
        REG_VERSION:   rd_value = VERSION;
        default:       rd_value = '0;
      endcase
    end
  end

  // Captures pre-edge register state, so a simultaneous write or increment is seen on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_mm.readdata      <= '0;
      reg_mm.readdatavalid <= 1'b0;
    end else begin
      reg_mm.readdatavalid <= reg_mm.read;
      if (reg_mm.read) reg_mm.readdata <= rd_value;
    end
  end

endmodule

// File: tb/tb_registers_controller.sv
// tb/tb_registers_controller.sv - scoreboard bench for registers_controller
module tb_registers_controller;

  localparam logic [31:0] VERSION = 32'h0001_0000;

  logic clk;
  logic rst_n;
  logic msg_enter;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  avalon_mm_if bus ();

  registers_controller #(
    .ADDR_BASE (32'd0),
    .VERSION   (VERSION)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_enter (msg_enter),
    .reg_mm    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] expv);
    bus.address = addr;
    bus.read    = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus.address   = addr;
    bus.writedata = data;
    bus.write     = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    msg_enter = 1'b0;
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          checks++;
          if (bus.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL waitrequest got=%b want=0", bus.waitrequest);
          end
          if (bus.readdatavalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_valid got readdata=%h want no pulse", bus.readdata);
            end else begin
              e = exp_q.pop_front();
              if (bus.readdata !== e) begin
                errors++;
                $display("FAIL readdata got=%h want=%h", bus.readdata, e);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h want valid=0 data=0", bus.readdatavalid, bus.readdata);
    end
    rst_n = 1'b1;
    idle();

    // reset values
    do_read(0, 32'h0);
    do_read(1, 32'h1);
    do_read(2, 32'h0);
    do_read(3, VERSION);
    idle();

    // debug scratch
    do_write(2, 32'hDEAD_BEEF);
    idle();
    do_read(2, 32'hDEAD_BEEF);
    idle();

    // counting: 10 edges, read on the 11th returns the old value
    do_read(0, 32'h0);
    msg_enter = 1'b1;
    repeat (10) idle();
    do_read(0, 32'h0000_000A);
    msg_enter = 1'b0;
    do_read(0, 32'h0000_000B);

    // counter disabled
    do_write(1, 32'h0);
    msg_enter = 1'b1;
    repeat (5) idle();
    msg_enter = 1'b0;
    do_read(0, 32'h0000_000B);
    do_read(1, 32'h0);
    do_write(1, 32'h3);
    do_read(0, 32'h0);
    do_read(1, 32'h1);

    // read-only and unmapped writes dropped
    msg_enter = 1'b1;
    repeat (4) idle();
    msg_enter = 1'b0;
    do_write(0, 32'h1234_5678);
    do_write(3, 32'h1234_5678);
    do_write(7, 32'h1234_5678);
    do_read(0, 32'h4);
    do_read(3, VERSION);
    do_read(7, 32'h0);
    do_read(2, 32'hDEAD_BEEF);

    // read and write together return the pre-write value
    bus.address = 2;
    bus.writedata = 32'h0000_0055;
    bus.write = 1'b1;
    bus.read = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    idle();
    bus.write = 1'b0;
    bus.read = 1'b0;
    do_read(2, 32'h0000_0055);

    // clear wins over a coincident increment
    msg_enter = 1'b1;
    do_write(1, 32'h3);
    msg_enter = 1'b0;
    do_read(0, 32'h0);

    // count to 20, then reset in the cycle after a read
    msg_enter = 1'b1;
    repeat (20) idle();
    msg_enter = 1'b0;
    do_read(0, 32'd20);
    msg_enter = 1'b1;
    bus.address = 2;
    bus.read = 1'b1;
    idle();
    bus.read = 1'b0;
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== 32'h0000_0055) begin
      errors++;
      $display("FAIL pre_reset_read got valid=%b data=%h want valid=1 data=00000055", bus.readdatavalid, bus.readdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h want valid=0 data=0", bus.readdatavalid, bus.readdata);
    end
    repeat (2) idle();
    msg_enter = 1'b0;
    rst_n = 1'b1;
    idle();
    do_read(0, 32'h0);
    do_read(2, 32'h0);
    do_read(1, 32'h1);

    repeat (3) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_valid got pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
